debug_scan_master: RTL and testbench

Host-side JTAG scan engine for the CPU debug module. Drives TCK/TMS/TDI and samples TDO to walk a standard IEEE 1149.1 TAP through IR and DR scans. Lets on-chip logic or a test bench issue 2-bit IR / 38-bit DR transactions to the debug TAP over its serial interface, without an external cable. It is the initiator end of the serial link whose responder is the debug module's TCK-domain shift logic.

---
 rtl/debug_scan_pkg.sv | 21 ++
 rtl/debug_scan_tck_gen.sv | 39 +++
 rtl/debug_scan_master.sv | 155 +++++++++++++++
 tb/tb_debug_scan_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_scan_pkg.sv
// Shared constants and FSM state type for the JTAG debug scan master.
package debug_scan_pkg;

  localparam int IR_WIDTH_DEF = 2;
  localparam int DR_WIDTH_DEF = 38;
  localparam int INIT_PERIODS = 6;

  // TMS sequences around the shift phase, LSB is the first TCK period
  localparam logic [3:0] TMS_IR_PRE = 4'b0011;
  localparam logic [2:0] TMS_DR_PRE = 3'b001;
  localparam logic [1:0] TMS_POST   = 2'b01;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_IR_SEQ,
    ST_DR_SEQ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// TCK generator: low phase then high phase, TCK_DIV clk cycles each, with
// strobes on the last cycle of each phase.
module debug_scan_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase_end;

  assign phase_end = en && (cnt == LAST);
  assign rise_stb  = phase_end && !tck;
  assign fall_stb  = phase_end && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (phase_end) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_scan_master.sv
// Host-side JTAG scan engine: resets the TAP, then runs IR and/or DR scans
// on command and returns the captured DR bits.
module debug_scan_master
  import debug_scan_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir_en,
  input  logic                cmd_dr_en,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int MAX_W = (DR_WIDTH > IR_WIDTH) ? DR_WIDTH : IR_WIDTH;
  localparam int PW    = $clog2(MAX_W + 6);

  state_t              state;
  logic [PW-1:0]       per;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [DR_WIDTH-1:0] dr_sr;
  logic [DR_WIDTH-1:0] cap;
  logic                dr_en_q;
  logic                tck_en, rise_stb, fall_stb;
  logic                is_ir, last_per, in_shift, next_shift;
  int                  cur, nxt;

  // TMS level for period n of an IR (ir=1) or DR (ir=0) sequence
  function automatic logic tms_at(input logic ir, input int n);
    int pre, w;
    pre = ir ? 4 : 3;
    w   = ir ? IR_WIDTH : DR_WIDTH;
    if (n < pre)     return ir ? TMS_IR_PRE[n[1:0]] : TMS_DR_PRE[n[1:0]];
    if (n < pre + w) return n == pre + w - 1;
    return (n == pre + w) ? TMS_POST[0] : TMS_POST[1];
  endfunction

  function automatic logic shift_at(input logic ir, input int n);
    int pre, w;
    pre = ir ? 4 : 3;
    w   = ir ? IR_WIDTH : DR_WIDTH;
    return (n >= pre) && (n < pre + w);
  endfunction

  assign cur        = int'(per);
  assign nxt        = cur + 1;
  assign is_ir      = (state == ST_IR_SEQ);
  assign last_per   = (cur == (is_ir ? IR_WIDTH + 5 : DR_WIDTH + 4));
  assign in_shift   = shift_at(is_ir, cur);
  assign next_shift = shift_at(is_ir, nxt);
  assign tck_en     = (state == ST_INIT) || (state == ST_IR_SEQ) || (state == ST_DR_SEQ);
  assign cmd_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign rsp_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tck_en),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // tms/tdi change on fall_stb, i.e. at the start of the next low phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      per     <= '0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
      rsp_dr  <= '0;
      cap     <= '0;
      ir_sr   <= '0;
      dr_sr   <= '0;
      dr_en_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (fall_stb) begin
            if (cur == INIT_PERIODS - 1) begin
              state <= ST_IDLE;
              per   <= '0;
              tms   <= 1'b0;
            end else begin
              per <= per + 1'b1;
              tms <= (nxt < INIT_PERIODS - 1);
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (cmd_valid) begin
            ir_sr   <= cmd_ir;
            dr_sr   <= cmd_dr;
            dr_en_q <= cmd_dr_en;
            per     <= '0;
            if (cmd_ir_en) begin
              state <= ST_IR_SEQ;
              tms   <= tms_at(1'b1, 0);
            end else if (cmd_dr_en) begin
              state <= ST_DR_SEQ;
              tms   <= tms_at(1'b0, 0);
            end else begin
              state <= ST_DONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IR_SEQ, ST_DR_SEQ: begin
          if (rise_stb && !is_ir && in_shift)
            cap <= {tdo, cap[DR_WIDTH-1:1]};
          if (fall_stb) begin
            if (last_per) begin
              per <= '0;
              tdi <= 1'b0;
              if (is_ir && dr_en_q) begin
                state <= ST_DR_SEQ;
                tms   <= tms_at(1'b0, 0);
              end else begin
                state <= ST_DONE;
                tms   <= 1'b0;
                if (!is_ir) rsp_dr <= cap;
              end
            end else begin
              per <= per + 1'b1;
              tms <= tms_at(is_ir, nxt);
              if (next_shift) begin
                tdi <= is_ir ? ir_sr[0] : dr_sr[0];
                if (is_ir) ir_sr <= ir_sr >> 1;
                else       dr_sr <= dr_sr >> 1;
              end else begin
                tdi <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master with a behavioural IEEE 1149.1 TAP
// model on the serial side.
module tb_debug_scan_master;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int DIV = 4;
  localparam logic [DRW-1:0] CAPTURE = 38'h1555555555;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ir_en = 1'b0;
  logic           cmd_dr_en = 1'b0;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [DRW-1:0] rsp_dr;

  int n_chk = 0;
  int n_fail = 0;

  int             tap_st = TLR;
  logic [DRW-1:0] tap_dr = '0;
  logic [DRW-1:0] dr_upd = '0;
  logic [IRW-1:0] tap_ir = '0;
  logic [IRW-1:0] ir_upd = '0;
  bit             tms_log[$];
  bit             tdi_log[$];

  always #5 clk = ~clk;

  assign tdo = tap_dr[0];

  debug_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir_en (cmd_ir_en),
    .cmd_dr_en (cmd_dr_en),
    .cmd_ir    (cmd_ir),
    .cmd_dr    (cmd_dr),
    .rsp_valid (rsp_valid),
    .rsp_dr    (rsp_dr),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  initial forever begin
    @(posedge tck);
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    case (tap_st)
      CAPDR:   tap_dr = CAPTURE;
      SHDR:    tap_dr = {tdi, tap_dr[DRW-1:1]};
      UPDR:    dr_upd = tap_dr;
      CAPIR:   tap_ir = 2'b01;
      SHIR:    tap_ir = {tdi, tap_ir[IRW-1:1]};
      UPIR:    ir_upd = tap_ir;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  task automatic send(input logic ie, input logic de, input logic [IRW-1:0] ir,
                      input logic [DRW-1:0] dr);
    @(negedge clk);
    cmd_ir_en = ie;
    cmd_dr_en = de;
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts clk edges until rsp_valid; lat = -1 when the budget runs out
  task automatic wait_rsp(input int from, input int budget, output int lat);
    lat = -1;
    for (int k = from + 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int base;
    logic [5:0] pat;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL rst_tck got=%0b want=0", tck); end
    n_chk++; if (tms !== 1'b1) begin n_fail++; $display("FAIL rst_tms got=%0b want=1", tms); end
    n_chk++; if (tdi !== 1'b0) begin n_fail++; $display("FAIL rst_tdi got=%0b want=0", tdi); end
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0b want=0", cmd_ready); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got=%0b want=1", busy); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid); end
    n_chk++; if (rsp_dr !== '0) begin n_fail++; $display("FAIL rst_rsp_dr got=%0h want=0", rsp_dr); end
    base = tms_log.size();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      #1;
      if (k == 47) begin
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_early got=%0b want=0", cmd_ready); end
      end
    end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_48 got=%0b want=1", cmd_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_48 got=%0b want=0", busy); end
    n_chk++; if (tms_log.size() - base !== 6) begin n_fail++; $display("FAIL init_edges got=%0d want=6", tms_log.size() - base); end
    for (int i = 0; i < 6; i++) pat[i] = tms_log[base + i];
    n_chk++; if (pat !== 6'b011111) begin n_fail++; $display("FAIL init_tms got=%b want=011111", pat); end
    n_chk++; if (tap_st !== RTI) begin n_fail++; $display("FAIL init_tap_state got=%0d want=%0d", tap_st, RTI); end
  endtask

  task automatic test_dr_scan;
    int base, lat;
    logic [42:0] tpat, dpat, texp, dexp;
    base = tms_log.size();
    send(1'b0, 1'b1, '0, 38'h2A12345678);
    wait_rsp(0, 1000, lat);
    n_chk++; if (lat !== 344) begin n_fail++; $display("FAIL dr_latency got=%0d want=344", lat); end
    n_chk++; if (rsp_dr !== CAPTURE) begin n_fail++; $display("FAIL dr_rsp got=%0h want=%0h", rsp_dr, CAPTURE); end
    n_chk++; if (dr_upd !== 38'h2A12345678) begin n_fail++; $display("FAIL dr_target got=%0h want=2a12345678", dr_upd); end
    n_chk++; if (tms_log.size() - base !== 43) begin n_fail++; $display("FAIL dr_edges got=%0d want=43", tms_log.size() - base); end
    for (int i = 0; i < 43; i++) begin
      tpat[i] = tms_log[base + i];
      dpat[i] = tdi_log[base + i];
    end
    texp = '0;
    texp[0]  = 1'b1;
    texp[40] = 1'b1;
    texp[41] = 1'b1;
    dexp = {2'b00, 38'h2A12345678, 3'b000};
    n_chk++; if (tpat !== texp) begin n_fail++; $display("FAIL dr_tms got=%0h want=%0h", tpat, texp); end
    n_chk++; if (dpat !== dexp) begin n_fail++; $display("FAIL dr_tdi got=%0h want=%0h", dpat, dexp); end
    n_chk++; if (tap_st !== RTI) begin n_fail++; $display("FAIL dr_tap_state got=%0d want=%0d", tap_st, RTI); end
  endtask

  task automatic test_ir_scan;
    int base, lat;
    logic [7:0] tpat, dpat;
    base = tms_log.size();
    send(1'b1, 1'b0, 2'b10, '0);
    wait_rsp(0, 1000, lat);
    n_chk++; if (lat !== 64) begin n_fail++; $display("FAIL ir_latency got=%0d want=64", lat); end
    n_chk++; if (rsp_dr !== CAPTURE) begin n_fail++; $display("FAIL ir_rsp_kept got=%0h want=%0h", rsp_dr, CAPTURE); end
    n_chk++; if (ir_upd !== 2'b10) begin n_fail++; $display("FAIL ir_target got=%0b want=10", ir_upd); end
    n_chk++; if (tms_log.size() - base !== 8) begin n_fail++; $display("FAIL ir_edges got=%0d want=8", tms_log.size() - base); end
    for (int i = 0; i < 8; i++) begin
      tpat[i] = tms_log[base + i];
      dpat[i] = tdi_log[base + i];
    end
    n_chk++; if (tpat !== 8'b01100011) begin n_fail++; $display("FAIL ir_tms got=%b want=01100011", tpat); end
    n_chk++; if (dpat !== 8'b00100000) begin n_fail++; $display("FAIL ir_tdi got=%b want=00100000", dpat); end
    @(posedge clk);
    #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ir_rsp_pulse got=%0b want=0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    int base, lat, lat2, k;
    base = tms_log.size();
    @(negedge clk);
    cmd_ir_en = 1'b1;
    cmd_dr_en = 1'b1;
    cmd_ir    = 2'b01;
    cmd_dr    = 38'h0F0F0F0F0F;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_ir_en = 1'b0;
    cmd_dr    = 38'h30C30C30C3;
    wait_rsp(0, 2000, lat);
    n_chk++; if (lat !== 408) begin n_fail++; $display("FAIL b2b_latency got=%0d want=408", lat); end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done got=%0b want=1", cmd_ready); end
    n_chk++; if (ir_upd !== 2'b01) begin n_fail++; $display("FAIL b2b_ir_target got=%0b want=01", ir_upd); end
    n_chk++; if (dr_upd !== 38'h0F0F0F0F0F) begin n_fail++; $display("FAIL b2b_dr_target1 got=%0h want=0f0f0f0f0f", dr_upd); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%0b want=1", busy); end
    n_chk++; if (tms !== 1'b1) begin n_fail++; $display("FAIL b2b_second_tms got=%0b want=1", tms); end
    k = 0;
    while (!tck && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++; if (k !== 4) begin n_fail++; $display("FAIL b2b_first_rise got=%0d want=4", k); end
    wait_rsp(k, 2000, lat2);
    n_chk++; if (lat2 !== 344) begin n_fail++; $display("FAIL b2b_latency2 got=%0d want=344", lat2); end
    n_chk++; if (dr_upd !== 38'h30C30C30C3) begin n_fail++; $display("FAIL b2b_dr_target2 got=%0h want=30c30c30c3", dr_upd); end
    n_chk++; if (tms_log.size() - base !== 94) begin n_fail++; $display("FAIL b2b_edges got=%0d want=94", tms_log.size() - base); end
  endtask

  task automatic test_noop;
    int base;
    base = tms_log.size();
    send(1'b0, 1'b0, 2'b11, 38'h3FFFFFFFFF);
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL noop_rsp got=%0b want=1", rsp_valid); end
    n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL noop_tck got=%0b want=0", tck); end
    n_chk++; if (rsp_dr !== CAPTURE) begin n_fail++; $display("FAIL noop_rsp_dr got=%0h want=%0h", rsp_dr, CAPTURE); end
    @(posedge clk);
    #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL noop_rsp_pulse got=%0b want=0", rsp_valid); end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL noop_ready got=%0b want=1", cmd_ready); end
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (tms_log.size() !== base) begin n_fail++; $display("FAIL noop_edges got=%0d want=%0d", tms_log.size(), base); end
  endtask

  task automatic test_reset_mid_scan;
    bit seen;
    send(1'b0, 1'b1, '0, 38'h2A12345678);
    repeat (23 * 2 * DIV + 5) @(posedge clk);
    #1;
    n_chk++; if (tck !== 1'b1) begin n_fail++; $display("FAIL mid_tck_high got=%0b want=1", tck); end
    n_chk++; if (tap_st !== SHDR) begin n_fail++; $display("FAIL mid_tap_shift got=%0d want=%0d", tap_st, SHDR); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tck got=%0b want=0", tck); end
    n_chk++; if (tms !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tms got=%0b want=1", tms); end
    n_chk++; if (rsp_dr !== '0) begin n_fail++; $display("FAIL mid_rst_rsp_dr got=%0h want=0", rsp_dr); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy got=%0b want=1", busy); end
    seen = rsp_valid;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen |= rsp_valid;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      #1;
      seen |= rsp_valid;
      if (k == 47) begin
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_early got=%0b want=0", cmd_ready); end
      end
    end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_48 got=%0b want=1", cmd_ready); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got=%0b want=0", seen); end
    n_chk++; if (tap_st !== RTI) begin n_fail++; $display("FAIL mid_tap_state got=%0d want=%0d", tap_st, RTI); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_scan();
    test_back_to_back();
    test_noop();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
